// File: rtl/sv_packet_rx.sv
// rtl/sv_packet_rx.sv - packet receive stage: parity/destination filter into a show-ahead FIFO
// Optional statistics counters are built when PKT_STATS_EN is defined.
module sv_packet_rx #(
    parameter int          DEPTH      = 4,
    parameter logic [3:0]  BCAST_ADDR = 4'hF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [13:0] packet_in,
    input  logic [3:0]  my_addr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data,
    output logic [3:0]  out_dest,
    output logic        fifo_full,
    output logic        fifo_empty,
    output logic        drop_pulse,
    output logic        parity_err_pulse,
    output logic [15:0] rx_count,
    output logic [15:0] drop_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [11:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          full_q, empty_q;
    logic          drop_q, drop_d;
    logic          perr_q, perr_d;
    logic          cand, par_ok, addr_ok, want_push, push, pop;
    logic [11:0]   head;

    always_comb begin
        cand      = packet_in[0];
        par_ok    = (^packet_in[9:2]) == packet_in[1];
        addr_ok   = (packet_in[13:10] == my_addr) || (packet_in[13:10] == BCAST_ADDR);
        want_push = cand && par_ok && addr_ok;
        pop       = !empty_q && out_ready;
        // A full FIFO still accepts when the head leaves on the same edge.
        push      = want_push && (!full_q || pop);
        drop_d    = want_push && full_q && !pop;
        perr_d    = cand && !par_ok;
        count_d   = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            drop_q   <= 1'b0;
            perr_q   <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
            full_q  <= (count_d == CW'(DEPTH));
            empty_q <= (count_d == '0);
            drop_q  <= drop_d;
            perr_q  <= perr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= packet_in[13:2];
    end

    assign head             = mem_q[rd_ptr_q];
    assign out_valid        = !empty_q;
    assign out_data         = empty_q ? 8'h00 : head[7:0];
    assign out_dest         = empty_q ? 4'h0 : head[11:8];
    assign fifo_full        = full_q;
    assign fifo_empty       = empty_q;
    assign drop_pulse       = drop_q;
    assign parity_err_pulse = perr_q;

`ifdef PKT_STATS_EN
    logic [15:0] rx_cnt_q, drop_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_cnt_q   <= '0;
            drop_cnt_q <= '0;
        end else begin
            if (push && rx_cnt_q != 16'hFFFF) rx_cnt_q <= rx_cnt_q + 16'd1;
            if ((drop_d || perr_d) && drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
        end
    end

    assign rx_count   = rx_cnt_q;
    assign drop_count = drop_cnt_q;
`else
    assign rx_count   = 16'h0;
    assign drop_count = 16'h0;
`endif

endmodule

// File: tb/tb_sv_packet_rx.sv
// tb/tb_sv_packet_rx.sv - self-checking bench for sv_packet_rx against a queue-based model
module tb_sv_packet_rx;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [13:0] pkt;
    logic [3:0]  my_addr;
    logic        out_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [3:0]  out_dest;
    logic        fifo_full, fifo_empty, drop_pulse, parity_err_pulse;
    logic [15:0] rx_count, drop_count;

    int checks = 0;
    int failures = 0;

    logic [11:0] mq[$];
    bit          m_drop, m_perr;
    int          m_rx, m_dc;

    sv_packet_rx #(.DEPTH(DEPTH), .BCAST_ADDR(4'hF)) dut (
        .clk(clk), .rst(rst), .packet_in(pkt), .my_addr(my_addr),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_dest(out_dest), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
        .drop_pulse(drop_pulse), .parity_err_pulse(parity_err_pulse),
        .rx_count(rx_count), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [13:0] mk(input logic [3:0] d, input logic [7:0] data, input bit good);
        return {d, data, (^data) ^ !good, 1'b1};
    endfunction

    task automatic model_clear();
        mq.delete();
        m_drop = 0; m_perr = 0; m_rx = 0; m_dc = 0;
    endtask

    // Applies the receive rules to the inputs present at this edge.
    task automatic model_edge();
        bit pop, pok, aok, want, room;
        pop  = (mq.size() > 0) && out_ready;
        pok  = ((^pkt[9:2]) == pkt[1]);
        aok  = (pkt[13:10] == my_addr) || (pkt[13:10] == 4'hF);
        want = pkt[0] && pok && aok;
        room = (mq.size() < DEPTH) || pop;
        if (pop) mq.delete(0);
        if (want && room) begin
            mq.push_back(pkt[13:2]);
            if (m_rx < 65535) m_rx++;
        end
        m_drop = want && !room;
        m_perr = pkt[0] && !pok;
        if ((m_drop || m_perr) && m_dc < 65535) m_dc++;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".out_valid"}, out_valid, mq.size() > 0);
        if (mq.size() > 0) begin
            chk({tag, ".out_data"}, out_data, mq[0][7:0]);
            chk({tag, ".out_dest"}, out_dest, mq[0][11:8]);
        end
        chk({tag, ".fifo_full"}, fifo_full, mq.size() == DEPTH);
        chk({tag, ".fifo_empty"}, fifo_empty, mq.size() == 0);
        chk({tag, ".drop_pulse"}, drop_pulse, m_drop);
        chk({tag, ".parity_err_pulse"}, parity_err_pulse, m_perr);
`ifdef PKT_STATS_EN
        chk({tag, ".rx_count"}, rx_count, m_rx);
        chk({tag, ".drop_count"}, drop_count, m_dc);
`else
        chk({tag, ".rx_count"}, rx_count, 0);
        chk({tag, ".drop_count"}, drop_count, 0);
`endif
    endtask

    task automatic cycle(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    initial begin
        logic [7:0] d;
        rst = 1'b1; pkt = '0; my_addr = 4'h3; out_ready = 1'b0;
        model_clear();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst.out_valid", out_valid, 0);
        chk("rst.out_data", out_data, 0);
        chk("rst.out_dest", out_dest, 0);
        chk("rst.fifo_empty", fifo_empty, 1);
        chk("rst.fifo_full", fifo_full, 0);
        chk("rst.drop_pulse", drop_pulse, 0);
        chk("rst.parity_err_pulse", parity_err_pulse, 0);
        chk("rst.rx_count", rx_count, 0);
        chk("rst.drop_count", drop_count, 0);
        rst = 1'b0;

        // Single matching packet, visible one cycle after sampling
        out_ready = 1'b1; pkt = 14'h0E95;
        cycle("t2.push");
        chk("t2.valid", out_valid, 1);
        chk("t2.data", out_data, 8'hA5);
        chk("t2.dest", out_dest, 4'h3);
        pkt = '0;
        cycle("t2.pop");
        chk("t2.empty_after_pop", fifo_empty, 1);

        // Other destination is silently discarded
        pkt = 14'h1D55;
        cycle("t3");
        chk("t3.empty", fifo_empty, 1);
        chk("t3.no_perr", parity_err_pulse, 0);
        chk("t3.no_drop", drop_pulse, 0);

        // Parity error pulses for exactly one cycle
        pkt = 14'h0E97;
        cycle("t4.err");
        chk("t4.perr", parity_err_pulse, 1);
        chk("t4.empty", fifo_empty, 1);
        pkt = '0;
        cycle("t4.after");
        chk("t4.perr_cleared", parity_err_pulse, 0);

        // Overflow with broadcast packets, then drain
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            pkt = 14'h3C07;
            cycle("t5.fill");
            if (i == 3) chk("t5.full_after_4th", fifo_full, 1);
            if (i == 4) chk("t5.drop_on_5th", drop_pulse, 1);
        end
        pkt = '0; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("t5.drain_data", out_data, 8'h01);
            cycle("t5.drain");
        end
        chk("t5.empty_after_drain", fifo_empty, 1);

        // Full FIFO with simultaneous pop and push, then reset mid-stream
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            d = 8'($urandom);
            pkt = mk(4'hF, d, 1'b1);
            cycle("t6.fill");
        end
        out_ready = 1'b1; pkt = 14'h0E95;
        cycle("t6.pushpop");
        chk("t6.full_stays", fifo_full, 1);
        chk("t6.no_drop", drop_pulse, 0);
        pkt = mk(4'h3, 8'h3C, 1'b1);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        model_clear();
        chk("t6.rst_valid", out_valid, 0);
        chk("t6.rst_empty", fifo_empty, 1);
        chk("t6.rst_full", fifo_full, 0);
        chk("t6.rst_rx_count", rx_count, 0);
        @(posedge clk);
        #1;
        rst = 1'b0; pkt = '0;
        cycle("t6.post_rst");

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            logic [3:0] dst;
            int sel;
            if ($urandom_range(0, 63) == 0) my_addr = 4'($urandom);
            sel = $urandom_range(0, 3);
            dst = (sel == 0) ? 4'hF : (sel == 1) ? 4'($urandom) : my_addr;
            d = 8'($urandom);
            pkt = mk(dst, d, $urandom_range(0, 4) != 0);
            if ($urandom_range(0, 4) == 0) pkt[0] = 1'b0;
            out_ready = ($urandom_range(0, 2) != 0);
            cycle("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
